// File: rtl/alu_pkg.sv
// Shared opcode constants, arbiter FSM state type and opcode legality helper
// for the ALU arbiter slice.
package alu_pkg;

  localparam logic [3:0] OP_ADD        = 4'b0000;
  localparam logic [3:0] OP_SUB        = 4'b0001;
  localparam logic [3:0] OP_AND        = 4'b0010;
  localparam logic [3:0] OP_OR         = 4'b0011;
  localparam logic [3:0] OP_XOR        = 4'b0100;
  localparam logic [3:0] OP_SHL        = 4'b0101;
  localparam logic [3:0] OP_SHR        = 4'b0110;
  localparam logic [3:0] OP_LAST_LEGAL = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_LAST_LEGAL);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: wrapping add/sub, bitwise logic and 1-bit shifts.
// For SUB, carry reports an unsigned borrow; shifts report the bit shifted out.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, result} = {1'b0, a} + {1'b0, b};
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        {carry, result} = {1'b0, a} - {1'b0, b};
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the requester favoured on a
// tie and flips to the other side whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt,
  output logic       gnt_valid
);

  logic rr_ptr;

  always_comb begin
    gnt_valid = |req;
    gnt       = (req == 2'b11) ? rr_ptr : req[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (advance) begin
      rr_ptr <= ~gnt;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters with round-robin grants
// and a single-entry, ID-tagged response buffer with backpressure.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_overflow,
  output logic                  rsp_zero,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [15:0]           op_count
);

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic             id_q;

  logic             gnt, gnt_valid, accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry, alu_overflow, alu_zero;

  assign accept = (state == IDLE) && gnt_valid;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  assign sel_a  = gnt ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
  assign sel_b  = gnt ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
  assign sel_op = gnt ? req_op[4 +: 4]        : req_op[0 +: 4];

  alu #(.WIDTH(WIDTH)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow),
    .zero     (alu_zero)
  );

  // Ready is offered only to the current grant candidate and never under reset.
  always_comb begin
    req_ready = '0;
    if (!rst && accept) begin
      req_ready[gnt] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            op_q  <= sel_op;
            id_q  <= gnt;
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_q;
          // Illegal opcodes report a clean zero result regardless of the ALU.
          if (op_illegal(op_q)) begin
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b1;
          end else begin
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
            rsp_err      <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset corner
// cases and randomized transactions against an arithmetic reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*WIDTH-1:0] req_a, req_b;
  logic [7:0]        req_op;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [WIDTH-1:0]  rsp_result;
  logic              rsp_carry, rsp_overflow, rsp_zero, rsp_err, busy;
  logic [15:0]       op_count;

  int   tests = 0;
  int   fails = 0;
  logic prefModel;
  int   countModel;

  typedef struct {
    logic [1:0]  valid;
    logic [15:0] a0, b0;
    logic [3:0]  op0;
    logic [15:0] a1, b1;
    logic [3:0]  op1;
    int          hold;
    logic        expId;
    logic [15:0] expRes;
    logic        expC, expV, expZ, expErr;
  } vec_t;

  vec_t vecs[8];

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_carry    (rsp_carry),
    .rsp_overflow (rsp_overflow),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference ALU computed from signed/unsigned integer arithmetic.
  function automatic void refAlu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] res, output logic c, output logic v,
                                 output logic z, output logic e);
    int ua, ub, sa, sb, r;
    ua = {16'b0, a};
    ub = {16'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    res = '0; c = 1'b0; v = 1'b0; e = 1'b0; r = 0;
    case (op)
      4'd0: begin r = ua + ub; res = r[15:0]; c = (r > 65535);
                  v = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1: begin r = ua - ub; res = r[15:0]; c = (ua < ub);
                  v = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin r = (ua * 2) % 65536; res = r[15:0]; c = (ua >= 32768); end
      4'd6: begin r = ua / 2; res = r[15:0]; c = (ua % 2 == 1); end
      default: e = 1'b1;
    endcase
    z = !e && (res == 16'd0);
  endfunction

  function automatic logic modelGrant(input logic [1:0] valid);
    if (valid == 2'b11) return prefModel;
    return valid[1];
  endfunction

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] op0,
                               input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] op1);
    req_valid = valid;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_op    = {op1, op0};
  endtask

  // One full request -> response -> consume cycle, starting with the DUT idle.
  task automatic runTxn(input string tag, input logic [1:0] valid,
                        input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] op0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] op1,
                        input int hold, input logic expId, input logic [15:0] expRes,
                        input logic expC, input logic expV, input logic expZ, input logic expErr);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus(valid, a0, b0, op0, a1, b1, op1);
    @(negedge clk);
    checkOutput($sformatf("%s req_ready", tag), 32'(req_ready), expId ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput($sformatf("%s exec busy", tag), 32'(busy), 32'd1);
    checkOutput($sformatf("%s exec rsp_valid", tag), 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput($sformatf("%s rsp_valid", tag), 32'(rsp_valid), 32'd1);
    checkOutput($sformatf("%s rsp_id", tag), 32'(rsp_id), 32'(expId));
    checkOutput($sformatf("%s rsp_result", tag), 32'(rsp_result), 32'(expRes));
    checkOutput($sformatf("%s rsp_carry", tag), 32'(rsp_carry), 32'(expC));
    checkOutput($sformatf("%s rsp_overflow", tag), 32'(rsp_overflow), 32'(expV));
    checkOutput($sformatf("%s rsp_zero", tag), 32'(rsp_zero), 32'(expZ));
    checkOutput($sformatf("%s rsp_err", tag), 32'(rsp_err), 32'(expErr));
    checkOutput($sformatf("%s resp req_ready", tag), 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput($sformatf("%s hold%0d rsp_valid", tag, i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("%s hold%0d rsp_result", tag, i), 32'(rsp_result), 32'(expRes));
      checkOutput($sformatf("%s hold%0d req_ready", tag, i), 32'(req_ready), 32'd0);
      checkOutput($sformatf("%s hold%0d op_count", tag, i), 32'(op_count), 32'(countModel));
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready  = 1'b0;
    countModel = (countModel + 1) % 65536;
    prefModel  = ~expId;
    @(negedge clk);
    checkOutput($sformatf("%s consumed rsp_valid", tag), 32'(rsp_valid), 32'd0);
    checkOutput($sformatf("%s consumed busy", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s op_count", tag), 32'(op_count), 32'(countModel));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput($sformatf("%s rsp_valid", tag), 32'(rsp_valid), 32'd0);
    checkOutput($sformatf("%s busy", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s req_ready", tag), 32'(req_ready), 32'd0);
    checkOutput($sformatf("%s op_count", tag), 32'(op_count), 32'd0);
    checkOutput($sformatf("%s rsp_result", tag), 32'(rsp_result), 32'd0);
    checkOutput($sformatf("%s rsp_flags", tag),
                32'({rsp_id, rsp_carry, rsp_overflow, rsp_zero, rsp_err}), 32'd0);
  endtask

  initial begin
    logic [15:0] rres;
    logic        rc, rv, rz, re, g;
    logic [1:0]  rvalid;
    logic [15:0] ra0, rb0, ra1, rb1;
    logic [3:0]  rop0, rop1;

    vecs[0] = '{2'b11, 16'd10, 16'd5, OP_SUB, 16'd8, 16'd3, OP_AND, 1, 1'b0, 16'd5,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b11, 16'd10, 16'd5, OP_SUB, 16'd8, 16'd3, OP_AND, 0, 1'b1, 16'd0,      1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'b11, 16'h7FFF, 16'd1, OP_ADD, 16'd8, 16'd3, OP_XOR, 0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 16'h8000, 16'd1, OP_SUB, 16'd0, 16'd0, OP_ADD, 0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b10, 16'd0, 16'd0, OP_ADD, 16'd8, 16'd3, OP_XOR, 5, 1'b1, 16'd11,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b01, 16'h1234, 16'd5, 4'b1010, 16'd0, 16'd0, OP_ADD, 0, 1'b0, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{2'b11, 16'd10, 16'd5, OP_ADD, 16'd4, 16'd99, OP_SHL, 0, 1'b1, 16'd8,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 16'd10, 16'd5, OP_ADD, 16'd0, 16'd0, OP_ADD, 0, 1'b0, 16'd15,     1'b0, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    rsp_ready = 1'b0;
    applyStimulus(2'b11, 16'd1, 16'd2, OP_ADD, 16'd3, 16'd4, OP_ADD);
    prefModel  = 1'b0;
    countModel = 0;
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;

    foreach (vecs[i]) begin
      runTxn($sformatf("vec%0d", i), vecs[i].valid, vecs[i].a0, vecs[i].b0, vecs[i].op0,
             vecs[i].a1, vecs[i].b1, vecs[i].op1, vecs[i].hold, vecs[i].expId,
             vecs[i].expRes, vecs[i].expC, vecs[i].expV, vecs[i].expZ, vecs[i].expErr);
    end

    // Reset while the operation is executing.
    @(posedge clk); #1;
    applyStimulus(2'b01, 16'd10, 16'd5, OP_ADD, 16'd0, 16'd0, OP_ADD);
    @(posedge clk); #1;
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    checkResetState("rst_exec");
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
    prefModel  = 1'b0;
    countModel = 0;

    // Reset while the response is waiting to be consumed.
    @(posedge clk); #1;
    applyStimulus(2'b10, 16'd0, 16'd0, OP_ADD, 16'd7, 16'd2, OP_OR);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    checkOutput("rst_resp pre rsp_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    checkResetState("rst_resp");
    @(negedge clk);
    rst = 1'b0;
    prefModel  = 1'b0;
    countModel = 0;

    runTxn("post_rst", 2'b11, 16'd3, 16'd4, OP_OR, 16'd1, 16'd1, OP_ADD, 0,
           1'b0, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rvalid = 2'($urandom_range(1, 3));
      ra0 = 16'($urandom); rb0 = 16'($urandom); rop0 = 4'($urandom_range(0, 8));
      ra1 = 16'($urandom); rb1 = 16'($urandom); rop1 = 4'($urandom_range(0, 8));
      g = modelGrant(rvalid);
      if (g) refAlu(rop1, ra1, rb1, rres, rc, rv, rz, re);
      else   refAlu(rop0, ra0, rb0, rres, rc, rv, rz, re);
      runTxn($sformatf("rnd%0d", i), rvalid, ra0, rb0, rop0, ra1, rb1, rop1,
             int'($urandom_range(0, 2)), g, rres, rc, rv, rz, re);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
